csr_hpm: RTL

CSR_HPM -- requirements
Module: csr_hpm

---
 rtl/csr_hpm.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/csr_hpm.sv
// Hardware performance monitor CSRs: mhpmcounter3..31 / mhpmevent3..31 with
// event selection, privilege-mode inhibits, overflow flags and LCOFI request.
module csr_hpm #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned NUM_HPM    = 8,
    parameter int unsigned NUM_EVENTS = 16,
    parameter int unsigned EVSEL_W    = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  CSRWriteM,
    input  logic [11:0]           CSRAdrM,
    input  logic [XLEN-1:0]       CSRWriteValM,
    input  logic [1:0]            PrivilegeModeM,
    input  logic [31:0]           MCOUNTINHIBIT_REGW,
    input  logic [NUM_EVENTS-1:0] EventsM,
    output logic [XLEN-1:0]       CSRHPMReadValM,
    output logic                  CSRHPMHitM,
    output logic                  IllegalCSRHPMAccessM,
    output logic [31:0]           HPMOverflow_REGW,
    output logic                  LCOFIRequestM
);

    localparam int unsigned NH  = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam bit          X64 = (XLEN == 64);

    logic [63:0]        cnt_q [NH];
    logic [63:0]        cnt_d [NH];
    logic [EVSEL_W-1:0] sel_q [NH];
    logic [EVSEL_W-1:0] sel_d [NH];
    logic [NH-1:0]      of_q, of_d, minh_q, minh_d, sinh_q, sinh_d, uinh_q, uinh_d;
    logic               lcofi_q, lcofi_d;

    logic [6:0]  blk;
    logic [4:0]  slot;
    logic        is_cnt_lo, is_cnt_hi, is_evt_lo, is_evt_hi, wr_ok;
    logic [63:0] wdata;
    logic [3:0]  flags_wr;

    assign blk       = CSRAdrM[11:5];
    assign slot      = CSRAdrM[4:0];
    assign is_cnt_lo = (blk == 7'h58);
    assign is_cnt_hi = (blk == 7'h5C);
    assign is_evt_lo = (blk == 7'h19);
    assign is_evt_hi = (blk == 7'h39);

    assign CSRHPMHitM = (is_cnt_lo | is_cnt_hi | is_evt_lo | is_evt_hi) && (slot >= 5'd3);
    assign IllegalCSRHPMAccessM = CSRHPMHitM && (is_cnt_hi | is_evt_hi) && X64;
    assign wr_ok = CSRWriteM && CSRHPMHitM && !IllegalCSRHPMAccessM;

    assign wdata    = 64'(CSRWriteValM);
    // OF/MINH/SINH/UINH live in bits 63:60, reached through the h-register on RV32
    assign flags_wr = X64 ? wdata[63:60] : wdata[31:28];

    logic [NH-1:0] ev_on, mode_inh, inc;

    always_comb begin
        ev_on    = '0;
        mode_inh = '0;
        inc      = '0;
        for (int j = 0; j < NUM_HPM; j++) begin
            for (int k = 0; k < NUM_EVENTS; k++) begin
                if (32'(sel_q[j]) == 32'(k + 1)) ev_on[j] = EventsM[k];
            end
            case (PrivilegeModeM)
                2'b11:   mode_inh[j] = minh_q[j];
                2'b01:   mode_inh[j] = sinh_q[j];
                2'b00:   mode_inh[j] = uinh_q[j];
                default: mode_inh[j] = 1'b0;
            endcase
            inc[j] = ev_on[j] && !mode_inh[j] && !MCOUNTINHIBIT_REGW[j+3];
        end
    end

    logic [NH-1:0] wsel, of_wr, wrap;

    always_comb begin
        lcofi_d = 1'b0;
        wsel    = '0;
        of_wr   = '0;
        wrap    = '0;
        of_d    = of_q;
        minh_d  = minh_q;
        sinh_d  = sinh_q;
        uinh_d  = uinh_q;
        for (int j = 0; j < NH; j++) begin
            cnt_d[j] = cnt_q[j];
            sel_d[j] = sel_q[j];
        end
        for (int j = 0; j < NUM_HPM; j++) begin
            wsel[j]  = wr_ok && (32'(slot) == 32'(j + 3));
            of_wr[j] = wsel[j] && (X64 ? is_evt_lo : is_evt_hi);
            // A CSR write to either half wins over the increment for the whole counter
            if (wsel[j] && is_cnt_lo) begin
                if (X64) cnt_d[j] = wdata;
                else     cnt_d[j][31:0] = wdata[31:0];
            end else if (wsel[j] && is_cnt_hi) begin
                cnt_d[j][63:32] = wdata[31:0];
            end else if (inc[j]) begin
                {wrap[j], cnt_d[j]} = {1'b0, cnt_q[j]} + 65'd1;
            end
            if (wsel[j] && is_evt_lo) sel_d[j] = wdata[EVSEL_W-1:0];
            if (of_wr[j]) begin
                {of_d[j], minh_d[j], sinh_d[j], uinh_d[j]} = flags_wr;
            end else if (wrap[j]) begin
                of_d[j] = 1'b1;
            end
            if (wrap[j] && !of_q[j] && !of_wr[j]) lcofi_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j < NH; j++) begin
                cnt_q[j] <= '0;
                sel_q[j] <= '0;
            end
            of_q    <= '0;
            minh_q  <= '0;
            sinh_q  <= '0;
            uinh_q  <= '0;
            lcofi_q <= 1'b0;
        end else begin
            for (int j = 0; j < NH; j++) begin
                cnt_q[j] <= cnt_d[j];
                sel_q[j] <= sel_d[j];
            end
            of_q    <= of_d;
            minh_q  <= minh_d;
            sinh_q  <= sinh_d;
            uinh_q  <= uinh_d;
            lcofi_q <= lcofi_d;
        end
    end

    logic [XLEN-1:0] rd;
    logic [63:0]     evt_rd;

    always_comb begin
        rd     = '0;
        evt_rd = '0;
        for (int j = 0; j < NUM_HPM; j++) begin
            if (32'(slot) == 32'(j + 3)) begin
                evt_rd = {of_q[j], minh_q[j], sinh_q[j], uinh_q[j], 60'(sel_q[j])};
                if (is_cnt_lo)      rd = XLEN'(cnt_q[j]);
                else if (is_cnt_hi) rd = XLEN'(cnt_q[j][63:32]);
                else if (is_evt_lo) rd = XLEN'(evt_rd);
                else if (is_evt_hi) rd = XLEN'(evt_rd[63:32]);
            end
        end
        if (!CSRHPMHitM || IllegalCSRHPMAccessM) rd = '0;
    end

    assign CSRHPMReadValM = rd;

    always_comb begin
        HPMOverflow_REGW = '0;
        for (int j = 0; j < NUM_HPM; j++) HPMOverflow_REGW[j+3] = of_q[j];
    end

    assign LCOFIRequestM = lcofi_q;

endmodule
